// File: rtl/instruction_dispatcher.sv
// Buffers host-written GPU instructions in a circular FIFO and hands them to the
// control unit one at a time, holding each until doneInst or a timeout retires it.
module instruction_dispatcher #(
  parameter int INST_W     = 64,
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 1023,
  parameter int CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [INST_W-1:0]     data_in,
  input  logic                  printtingScreen,
  input  logic                  doneInst,
  input  logic                  clr_err,
  output logic [INST_W-1:0]     inst_out,
  output logic [3:0]            opCode,
  output logic                  en_execution,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  timeout_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RETIRE} state_t;

  state_t                  state_reg, state_next;
  logic [INST_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]        level_reg, level_next;
  logic                    full_reg, empty_reg;
  logic                    overflow_reg, timeout_err_reg, en_reg;
  logic [INST_W-1:0]       inst_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    pop, push, drop, timeout_hit;

  // A full FIFO can still accept a write when the head is popped in the same cycle.
  assign push = wr_req && (!full_reg || pop);
  assign drop = wr_req && !push;

  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_reg && !printtingScreen) begin
          state_next = ISSUE;
          pop        = 1'b1;
        end
      end
      ISSUE: state_next = WAIT_DONE;
      WAIT_DONE: begin
        // cnt_reg counts completed WAIT_DONE cycles, so this is the TIMEOUT-th one.
        if (doneInst) begin
          state_next = RETIRE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = RETIRE;
        end
      end
      RETIRE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LVL_W'(1);
    end
  end

  // Storage has no reset; pointers define validity. Read-before-write on a shared address.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= '0;
      full_reg        <= 1'b0;
      empty_reg       <= 1'b1;
      overflow_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
      en_reg          <= 1'b0;
      inst_reg        <= '0;
      cnt_reg         <= '0;
    end else begin
      state_reg  <= state_next;
      level_reg  <= level_next;
      full_reg   <= (level_next == LVL_W'(DEPTH));
      empty_reg  <= (level_next == '0);
      en_reg     <= (state_next == ISSUE) || (state_next == WAIT_DONE);
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
        inst_reg   <= mem[rd_ptr_reg];
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= '0;
      end else if (state_reg == WAIT_DONE) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      // A new error event wins over a coincident clear.
      overflow_reg    <= drop || (overflow_reg && !clr_err);
      timeout_err_reg <= timeout_hit || (timeout_err_reg && !clr_err);
    end
  end

  assign inst_out     = inst_reg;
  assign opCode       = inst_reg[3:0];
  assign en_execution = en_reg;
  assign fifo_full    = full_reg;
  assign fifo_empty   = empty_reg;
  assign level        = level_reg;
  assign overflow     = overflow_reg;
  assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher: a queue-based reference model checked every
// cycle, plus literal checks on issue order, issue spacing, timeout timing and flags.
module tb_instruction_dispatcher;

  localparam int W   = 64;
  localparam int DL  = 4;
  localparam int TO  = 1023;
  localparam int CW  = 10;
  localparam int DEP = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_req = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          printtingScreen = 1'b0;
  logic          doneInst = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  inst_out;
  logic [3:0]    opCode;
  logic          en_execution, fifo_full, fifo_empty, overflow, timeout_err;
  logic [DL:0]   level;

  instruction_dispatcher #(.INST_W(W), .DEPTH_LOG2(DL), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .data_in(data_in),
    .printtingScreen(printtingScreen), .doneInst(doneInst), .clr_err(clr_err),
    .inst_out(inst_out), .opCode(opCode), .en_execution(en_execution),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .level(level),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the queue of stored words plus who owns the control unit.
  logic [W-1:0] q[$];
  bit           m_valid = 0;
  bit           m_active = 0;   // an instruction has been handed out and not yet finished
  int           m_age = 0;      // cycles since hand-out; 0 = hand-out cycle
  bit           m_retire = 0;   // the one quiet cycle after finishing
  logic [W-1:0] m_inst = '0;
  bit           m_ovf = 0, m_terr = 0;
  bit           ovf_set, terr_set;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      q.delete();
      m_active = 0; m_age = 0; m_retire = 0; m_inst = '0;
      m_ovf = 0; m_terr = 0; m_valid = 1;
    end else begin
      ovf_set = 0; terr_set = 0;
      if (m_retire) begin
        m_retire = 0;
      end else if (m_active) begin
        if (m_age >= 1 && (doneInst || m_age == TO)) begin
          terr_set = !doneInst;
          m_active = 0;
          m_retire = 1;
        end else begin
          m_age++;
        end
      end else if (q.size() > 0 && !printtingScreen) begin
        m_inst = q.pop_front();
        m_active = 1;
        m_age = 0;
      end
      if (wr_req) begin
        if (q.size() < DEP) q.push_back(data_in);
        else ovf_set = 1;
      end
      m_ovf  = ovf_set  || (m_ovf  && !clr_err);
      m_terr = terr_set || (m_terr && !clr_err);
    end
  end

  // Per-cycle compare and issue log.
  logic [W-1:0] got[$];
  int           got_t[$];
  bit           en_prev = 0;

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("en_execution", en_execution, m_active);
      chk("inst_out", inst_out, m_inst);
      chk("opCode", opCode, m_inst[3:0]);
      chk("level", level, q.size());
      chk("fifo_full", fifo_full, q.size() == DEP);
      chk("fifo_empty", fifo_empty, q.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("timeout_err", timeout_err, m_terr);
    end
    if (en_execution === 1'b1 && !en_prev) begin
      got.push_back(inst_out);
      got_t.push_back(cyc);
      $display("issue %0d: inst=%h op=%0d cycle=%0d", got.size(), inst_out, opCode, cyc);
    end
    en_prev = (en_execution === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int n0;
  logic [W-1:0] y_word;

  initial begin
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_en", en_execution, 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_flags", {overflow, timeout_err}, 0);

    // Single instruction: write cycle, IDLE sees it, then en_execution in the third cycle.
    wr_req = 1'b1; data_in = 64'h1234_5678_9ABC_0001;
    tick(1);
    wr_req = 1'b0;
    chk("t1_level", level, 1);
    chk("t1_en_early", en_execution, 0);
    tick(1);
    chk("t1_en", en_execution, 1);
    chk("t1_op", opCode, 4'h1);
    tick(1);
    doneInst = 1'b1;
    tick(1);
    doneInst = 1'b0;
    chk("t1_retire_en", en_execution, 0);
    chk("t1_empty", fifo_empty, 1);
    tick(2);

    // 17 writes while printing: last one dropped.
    printtingScreen = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_req = 1'b1; data_in = 64'hC0DE_0000_0000_0100 + 64'(i);
      tick(1);
    end
    wr_req = 1'b0;
    chk("t2_level", level, 16);
    chk("t2_full", fifo_full, 1);
    chk("t2_ovf", overflow, 1);
    chk("t2_no_issue", en_execution, 0);

    // Drain with immediate completion: push order, one issue per 4 cycles.
    n0 = got.size();
    doneInst = 1'b1; printtingScreen = 1'b0;
    tick(16 * 4 + 3);
    chk("t3_count", got.size() - n0, 16);
    for (int i = 0; i < 16 && n0 + i < got.size(); i++) begin
      chk("t3_order", got[n0 + i], 64'hC0DE_0000_0000_0100 + 64'(i));
      if (i > 0) chk("t3_gap", got_t[n0 + i] - got_t[n0 + i - 1], 4);
    end
    chk("t3_empty", fifo_empty, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("t3_clr_ovf", overflow, 0);

    // Partial fill/drain, then a full refill so the pointers wrap mid-buffer.
    printtingScreen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_req = 1'b1; data_in = 64'hBEEF_0000_0000_0200 + 64'(i);
      tick(1);
    end
    wr_req = 1'b0;
    n0 = got.size();
    printtingScreen = 1'b0;
    tick(10 * 4 + 3);
    chk("t3b_count", got.size() - n0, 10);
    if (got.size() >= n0 + 10) chk("t3b_last", got[n0 + 9], 64'hBEEF_0000_0000_0209);
    printtingScreen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_req = 1'b1; data_in = 64'hF00D_0000_0000_0300 + 64'(i);
      tick(1);
    end
    wr_req = 1'b0;
    chk("t3c_full", fifo_full, 1);
    chk("t3c_ovf", overflow, 0);

    // Write into a full FIFO on the same cycle as the pop: accepted.
    n0 = got.size();
    y_word = 64'hABCD_0000_0000_040F;
    printtingScreen = 1'b0; wr_req = 1'b1; data_in = y_word;
    tick(1);
    wr_req = 1'b0;
    chk("t5_level", level, 16);
    chk("t5_ovf", overflow, 0);
    chk("t5_en", en_execution, 1);
    tick(17 * 4 + 3);
    chk("t5_count", got.size() - n0, 17);
    for (int i = 0; i < 16 && n0 + i < got.size(); i++)
      chk("t5_order", got[n0 + i], 64'hF00D_0000_0000_0300 + 64'(i));
    if (got.size() >= n0 + 17) chk("t5_tail", got[n0 + 16], y_word);

    // Timeout: first instruction never completes, the second is then issued.
    doneInst = 1'b0;
    n0 = got.size();
    wr_req = 1'b1; data_in = 64'h0000_0000_AAAA_0005;
    tick(1);
    data_in = 64'h0000_0000_BBBB_0006;
    tick(1);
    wr_req = 1'b0;
    tick(TO + 10);
    chk("t4_count", got.size() - n0, 2);
    if (got.size() >= n0 + 2) begin
      chk("t4_second", got[n0 + 1], 64'h0000_0000_BBBB_0006);
      chk("t4_gap", got_t[n0 + 1] - got_t[n0], TO + 3);
    end
    chk("t4_terr", timeout_err, 1);
    chk("t4_en", en_execution, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("t4_clr", timeout_err, 0);
    doneInst = 1'b1;
    tick(1);
    doneInst = 1'b0;
    chk("t4_retire", en_execution, 0);
    tick(3);

    // doneInst on the last allowed WAIT_DONE cycle: completion, no error.
    wr_req = 1'b1; data_in = 64'h0000_0000_CCCC_0007;
    tick(1);
    wr_req = 1'b0;
    tick(1);
    tick(TO);
    chk("t4b_still_en", en_execution, 1);
    doneInst = 1'b1;
    tick(1);
    doneInst = 1'b0;
    chk("t4b_en", en_execution, 0);
    chk("t4b_terr", timeout_err, 0);
    tick(2);

    // Reset while waiting with 5 words queued.
    n0 = got.size();
    for (int i = 0; i < 6; i++) begin
      wr_req = 1'b1; data_in = 64'hDEAD_0000_0000_0500 + 64'(i);
      tick(1);
    end
    wr_req = 1'b0;
    chk("t6_level", level, 5);
    chk("t6_en", en_execution, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_rst_en", en_execution, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_empty", fifo_empty, 1);
    tick(20);
    chk("t6_no_stale", got.size() - n0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_dispatcher.md
Name: instruction_dispatcher

Overview:
- Buffers GPU instructions written by the host bus interface and presents them to the control unit one at a time.
- Holds each instruction stable until the control unit reports completion via doneInst, then retires it.
- Never issues a new instruction while the screen is being printed.
- Sits between the host write bridge and the control unit / instruction decoder; drives en_execution and the instruction word.

Parameters:
- INST_W, 64, instruction width in bits; opCode is bits [3:0].
- DEPTH_LOG2, 4, FIFO depth exponent (depth = 16).
- TIMEOUT, 1023, maximum cycles in WAIT_DONE before the instruction is aborted; must be at least 1.
- CNT_W, 10, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- wr_req  in  1  host write strobe; one instruction is pushed per high cycle.
- data_in  in  INST_W  instruction word from the host.
- printtingScreen  in  1  print module busy; issue is blocked while high.
- doneInst  in  1  control unit reports the current instruction finished.
- clr_err  in  1  clears the sticky error flags.
- inst_out  out  INST_W  current instruction to the decoder.
- opCode  out  4  equals inst_out[3:0].
- en_execution  out  1  instruction valid for the control unit.
- fifo_full  out  1  FIFO holds DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- level  out  DEPTH_LOG2+1  number of stored entries.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.
- timeout_err  out  1  sticky: an instruction was aborted by timeout.

Behaviour:
- Clock and reset:
  - Single clk domain; all registers update on posedge clk.
  - reset is synchronous, active-high, and overrides all other inputs.
- Reset values:
  - FIFO pointers = 0, level = 0, fifo_empty = 1, fifo_full = 0.
  - state = IDLE, en_execution = 0, inst_out = 0.
  - overflow = 0, timeout_err = 0, timeout counter = 0.
- FIFO storage:
  - Circular buffer of DEPTH entries; read and write pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
  - level, fifo_full and fifo_empty are registered and reflect pushes/pops from the previous cycle.
  - Push occurs when wr_req=1 and (not full, or a pop happens in the same cycle).
  - wr_req=1 while full with no pop: the write is dropped and overflow is set the next cycle.
  - Pop occurs only on the IDLE->ISSUE transition.
  - Simultaneous push and pop: level is unchanged; both pointers advance.
- State machine (registered state):
  - IDLE:
    - Go to ISSUE when fifo_empty=0 and printtingScreen=0.
    - On that transition, load the head entry into inst_out and pop it.
  - ISSUE:
    - en_execution = 1; timeout counter cleared.
    - Next cycle go to WAIT_DONE unconditionally.
  - WAIT_DONE:
    - en_execution = 1; inst_out held stable; counter increments each cycle.
    - doneInst=1: go to RETIRE.
    - Counter reaches TIMEOUT with doneInst=0: set timeout_err, go to RETIRE.
    - doneInst and timeout in the same cycle: treated as done; timeout_err is not set.
  - RETIRE:
    - en_execution = 0 for exactly one cycle, so the control unit returns to its ready state.
    - Next cycle go to IDLE.
- Timing:
  - Minimum issue interval is 4 cycles (IDLE, ISSUE, WAIT_DONE with immediate done, RETIRE).
  - Latency from a write into an empty FIFO to en_execution=1 is 3 cycles when printtingScreen=0.
- printtingScreen:
  - Sampled only in IDLE.
  - Assertion after issue does not affect the current instruction; the control unit handles print preemption itself.
- doneInst is ignored in IDLE, ISSUE and RETIRE.
- clr_err clears both sticky flags the next cycle.
  - If clr_err coincides with a new error event, the set wins.
- Reset mid-operation (in any state): the FIFO contents are discarded and en_execution drops the cycle after reset.
- opCode is combinational from inst_out.

Test Plan:
- Reset, then push one instruction 0x...0001 with printtingScreen=0 -> en_execution=1 three cycles after wr_req, opCode=1; pulse doneInst -> en_execution=0 for the RETIRE cycle; fifo_empty=1.
- Push 17 instructions back-to-back while printtingScreen=1 -> level=16, fifo_full=1, overflow=1; 17th word absent from the issued sequence.
- Fill FIFO, release printtingScreen, return doneInst immediately each time -> 16 instructions issued in push order, one every 4 cycles; pointers wrap correctly when the buffer is refilled after drain.
- Issue an instruction, never assert doneInst -> after TIMEOUT cycles timeout_err=1 and the next instruction is issued; clr_err -> timeout_err=0 the next cycle.
- FIFO full, wr_req on the same cycle as the IDLE->ISSUE pop -> write accepted, level stays 16, overflow stays 0.
- Assert reset during WAIT_DONE with 5 entries queued -> next cycle en_execution=0, level=0, state IDLE; no stale instruction issued afterwards.
